snoop_arbiter: RTL and testbench
================================

SNOOP_ARBITER -- requirements
Module: snoop_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of snoop requesters sharing one DCache snoop port.
REQ-002 Parameter ADDR_W, default 32, physical address width.
REQ-003 Parameter USER_W, default 4, snoop user/id width.
REQ-004 Parameter DATA_W, default 64, snoop data beat width.
REQ-005 Parameter BEATS, default 8, data beats per snoop (power of 2, >=2).
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 req_valid  in  NUM_REQ  per-requester snoop request valid.
REQ-009 req_ready  out  NUM_REQ  per-requester request accept.
REQ-010 req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-011 req_user  in  NUM_REQ*USER_W  per-requester user, same packing.
REQ-012 resp_valid  out  NUM_REQ  per-requester data beat valid.
REQ-013 resp_ready  in  NUM_REQ  per-requester data beat accept.
REQ-014 resp_data  out  DATA_W  beat data, shared by all requesters.
REQ-015 resp_last  out  1  final beat marker, shared.
REQ-016 ac_valid / ac_ready  out / in  1 / 1  snoop address handshake toward DCache.
REQ-017 ac_addr / ac_user  out  ADDR_W / USER_W  registered snoop address and user.
REQ-018 cd_valid / cd_ready  in / out  1 / 1  snoop data handshake from DCache.
REQ-019 cd_data / cd_last / cd_user  in  DATA_W / 1 / USER_W  snoop data, last, echoed user.
REQ-020 err  out  1  sticky protocol-error flag.

Function
REQ-021 FSM states IDLE, ISSUE, DATA; exactly one snoop outstanding at any time.
REQ-022 IDLE: grant = first requester with req_valid set, scanning from rr_ptr upward modulo NUM_REQ; req_ready asserted combinationally only for that requester, only in IDLE.
REQ-023 On grant in cycle T: register addr, user, grant index; rr_ptr <= (index+1) mod NUM_REQ; state ISSUE; ac_valid high from T+1.
REQ-024 ISSUE: ac_valid=1, ac_addr/ac_user stable until ac_ready; on ac_valid&ac_ready go to DATA, beat counter cleared.
REQ-025 DATA: resp_valid[grant]=cd_valid, other resp_valid bits 0; resp_data=cd_data; resp_last=cd_last; cd_ready=resp_ready[grant]; zero added latency.
REQ-026 Each cd_valid&cd_ready increments beat counter (log2(BEATS) bits, wraps).
REQ-027 Beat with cd_last in DATA returns to IDLE next cycle; no new grant in the last-beat cycle.
REQ-028 err set if cd_last arrives with counter != BEATS-1, counter == BEATS-1 without cd_last, cd_user != registered user, or cd_valid outside DATA; err stays set until reset; FSM still follows cd_last.
REQ-029 Outside DATA: cd_ready=0, resp_valid=0.
REQ-030 req_valid dropped by a non-granted requester has no effect; granted request is captured and completes regardless of later req_valid.
REQ-031 No requester receives two consecutive grants while another requester holds req_valid continuously.

Reset
REQ-032 rst asserted: state IDLE, ac_valid=0, cd_ready=0, resp_valid=0, req_ready=0 while rst high, rr_ptr=0, counter=0, err=0, registered addr/user=0.
REQ-033 rst mid-ISSUE or mid-DATA aborts immediately; outstanding beats after release flagged via err (REQ-028).

Verification
REQ-034 Single request: req_valid[1]=1, addr 0x8000_1040, user 0x5 -> req_ready[1] in T, ac_valid T+1 with addr 0x8000_1040/user 0x5, 8 cd beats routed to resp_valid[1], IDLE after last, err=0.
REQ-035 All three request continuously from reset -> grant order 0,1,2,0, rr_ptr cycles 1,2,0,1.
REQ-036 Backpressure: ac_ready low 5 cycles then high; resp_ready[grant] toggles every cycle -> ac fields stable, cd_ready mirrors resp_ready, all 8 beats delivered in order.
REQ-037 Protocol errors: cd_last on beat 3 -> err=1, return to IDLE; cd_user 0x6 vs 0x5 -> err=1; err held until rst.
REQ-038 rst pulsed during DATA beat 4 -> all outputs at reset values next edge, next request granted to requester 0 first.

Source files
------------

// File: rtl/snoop_arbiter.sv
// Round-robin arbiter sharing one DCache snoop port among NUM_REQ requesters.
// One snoop is outstanding at a time: grant in IDLE, address in ISSUE, beats in DATA.
module snoop_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int USER_W  = 4,
    parameter int DATA_W  = 64,
    parameter int BEATS   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*USER_W-1:0] req_user,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_last,
    output logic                      ac_valid,
    input  logic                      ac_ready,
    output logic [ADDR_W-1:0]         ac_addr,
    output logic [USER_W-1:0]         ac_user,
    input  logic                      cd_valid,
    output logic                      cd_ready,
    input  logic [DATA_W-1:0]         cd_data,
    input  logic                      cd_last,
    input  logic [USER_W-1:0]         cd_user,
    output logic                      err,
    output logic [1:0]                dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [USER_W-1:0]  user_q;
    logic [CNT_W-1:0]   cnt;

    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W:0]     cand;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [USER_W-1:0]  gnt_user;
    logic               grant;
    logic               beat_fire;
    logic               beat_err;

    // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        gnt_user = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
                gnt_user = req_user[i*USER_W +: USER_W];
            end
        end
    end

    assign grant     = (state == S_IDLE) && gnt_found;
    assign beat_fire = (state == S_DATA) && cd_valid && cd_ready;
    assign beat_err  = (cd_valid && (state != S_DATA)) ||
                       (beat_fire && ((cd_last && (cnt != CNT_MAX)) ||
                                      (!cd_last && (cnt == CNT_MAX)) ||
                                      (cd_user != user_q)));

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and req_ready/cd_ready are pure functions of state and inputs.
    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        resp_valid = '0;
        cd_ready   = 1'b0;
        ac_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_found && !rst)
                    req_ready[gnt_idx] = 1'b1;
                if (gnt_found)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                ac_valid = 1'b1;
                if (ac_ready)
                    state_nx = S_DATA;
            end
            S_DATA: begin
                resp_valid[gnt_q] = cd_valid;
                cd_ready          = resp_ready[gnt_q];
                if (beat_fire && cd_last)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign resp_data = cd_data;
    assign resp_last = cd_last;
    assign ac_addr   = addr_q;
    assign ac_user   = user_q;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            gnt_q  <= '0;
            addr_q <= '0;
            user_q <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                addr_q <= gnt_addr;
                user_q <= gnt_user;
                gnt_q  <= gnt_idx;
                rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if ((state == S_ISSUE) && ac_ready)
                cnt <= '0;
            else if (beat_fire)
                cnt <= cnt + 1'b1;
            if (beat_err)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_snoop_arbiter.sv
// Directed bench for snoop_arbiter: grant order, address/data routing,
// backpressure, protocol-error flag and asynchronous reset mid-transfer.
module tb_snoop_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [95:0] req_addr;
    logic [11:0] req_user;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_ready;
    logic [63:0] resp_data;
    logic        resp_last;
    logic        ac_valid;
    logic        ac_ready;
    logic [31:0] ac_addr;
    logic [3:0]  ac_user;
    logic        cd_valid;
    logic        cd_ready;
    logic [63:0] cd_data;
    logic        cd_last;
    logic [3:0]  cd_user;
    logic        err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    snoop_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_user(req_user),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_last(resp_last),
        .ac_valid(ac_valid), .ac_ready(ac_ready),
        .ac_addr(ac_addr), .ac_user(ac_user),
        .cd_valid(cd_valid), .cd_ready(cd_ready),
        .cd_data(cd_data), .cd_last(cd_last), .cd_user(cd_user),
        .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bd(input int g, input int k);
        return 64'hC0DE_0000_0000_0000 | (64'(g) << 16) | 64'(k);
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] u);
        req_addr[i*32 +: 32] = a;
        req_user[i*4 +: 4]   = u;
    endtask

    // Expects the DUT in IDLE with req_valid already driven so that g wins.
    task automatic grant_issue(input int g, input logic [31:0] a, input logic [3:0] u,
                               input bit drop, input int stall);
        #1;
        check("req_ready_grant", 64'(req_ready), 64'(1) << g);
        tick();
        if (drop) req_valid = '0;
        for (int s = 0; s <= stall; s++) begin
            #1;
            check("ac_valid_issue", 64'(ac_valid), 64'd1);
            check("ac_addr_issue", 64'(ac_addr), 64'(a));
            check("ac_user_issue", 64'(ac_user), 64'(u));
            check("state_issue", 64'(dbg_state), 64'd1);
            check("req_ready_busy", 64'(req_ready), 64'd0);
            if (s < stall) tick();
        end
        ac_ready = 1'b1;
        tick();
        ac_ready = 1'b0;
        check("state_data", 64'(dbg_state), 64'd2);
        check("ac_valid_data", 64'(ac_valid), 64'd0);
    endtask

    task automatic beat(input int g, input int k, input bit last, input logic [3:0] u);
        cd_valid   = 1'b1;
        cd_data    = bd(g, k);
        cd_last    = last;
        cd_user    = u;
        resp_ready = 3'b111;
        #1;
        check("resp_valid_beat", 64'(resp_valid), 64'(1) << g);
        check("resp_data_beat", resp_data, bd(g, k));
        check("resp_last_beat", 64'(resp_last), 64'(last));
        check("cd_ready_beat", 64'(cd_ready), 64'd1);
        tick();
        cd_valid   = 1'b0;
        cd_last    = 1'b0;
        resp_ready = 3'b000;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int c;
        rst = 1'b1; req_valid = 3'b001; req_addr = '0; req_user = '0;
        resp_ready = '0; ac_ready = 1'b0; cd_valid = 1'b0; cd_data = '0;
        cd_last = 1'b0; cd_user = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_ac_valid", 64'(ac_valid), 64'd0);
        check("rst_cd_ready", 64'(cd_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ac_addr", 64'(ac_addr), 64'd0);
        check("rst_ac_user", 64'(ac_user), 64'd0);
        rst = 1'b0; req_valid = 3'b000;
        tick();

        // Single request on requester 1, request dropped after capture.
        set_req(1, 32'h8000_1040, 4'h5);
        req_valid = 3'b010;
        grant_issue(1, 32'h8000_1040, 4'h5, 1'b1, 0);
        for (int b = 0; b < 8; b++) beat(1, b, b == 7, 4'h5);
        check("single_idle", 64'(dbg_state), 64'd0);
        check("single_err", 64'(err), 64'd0);

        // All three requesting continuously from reset: grants 0,1,2,0.
        pulse_reset();
        set_req(0, 32'h1000_0000, 4'h1);
        set_req(1, 32'h1000_0100, 4'h2);
        set_req(2, 32'h1000_0200, 4'h3);
        req_valid = 3'b111;
        grant_issue(0, 32'h1000_0000, 4'h1, 1'b0, 0);
        for (int b = 0; b < 8; b++) beat(0, b, b == 7, 4'h1);
        grant_issue(1, 32'h1000_0100, 4'h2, 1'b0, 0);
        for (int b = 0; b < 8; b++) beat(1, b, b == 7, 4'h2);
        grant_issue(2, 32'h1000_0200, 4'h3, 1'b0, 0);
        for (int b = 0; b < 8; b++) beat(2, b, b == 7, 4'h3);
        grant_issue(0, 32'h1000_0000, 4'h1, 1'b0, 0);
        req_valid = 3'b000;
        for (int b = 0; b < 8; b++) beat(0, b, b == 7, 4'h1);
        check("rr_err", 64'(err), 64'd0);

        // Backpressure on requester 2: ac stalled 5 cycles, resp_ready toggling.
        set_req(2, 32'hA5A5_0000, 4'h3);
        req_valid = 3'b100;
        grant_issue(2, 32'hA5A5_0000, 4'h3, 1'b1, 5);
        k = 0;
        c = 0;
        while (k < 8 && c < 40) begin
            resp_ready = (c % 2 == 0) ? 3'b100 : 3'b011;
            cd_valid   = 1'b1;
            cd_data    = bd(2, k);
            cd_last    = (k == 7);
            cd_user    = 4'h3;
            #1;
            check("bp_cd_ready", 64'(cd_ready), 64'(resp_ready[2]));
            check("bp_resp_valid", 64'(resp_valid), 64'b100);
            check("bp_resp_data", resp_data, bd(2, k));
            if (resp_ready[2]) k++;
            c++;
            tick();
        end
        cd_valid = 1'b0; cd_last = 1'b0; resp_ready = '0;
        check("bp_beats", 64'(k), 64'd8);
        check("bp_cycles", 64'(c), 64'd15);
        check("bp_idle", 64'(dbg_state), 64'd0);
        check("bp_err", 64'(err), 64'd0);

        // Early last on beat 3 flags err and still returns to IDLE.
        set_req(0, 32'h4000_0000, 4'h5);
        req_valid = 3'b001;
        grant_issue(0, 32'h4000_0000, 4'h5, 1'b1, 0);
        for (int b = 0; b < 4; b++) begin
            check("early_err_before", 64'(err), 64'd0);
            beat(0, b, b == 3, 4'h5);
        end
        check("early_err", 64'(err), 64'd1);
        check("early_idle", 64'(dbg_state), 64'd0);
        repeat (3) tick();
        check("early_err_held", 64'(err), 64'd1);
        pulse_reset();
        check("err_cleared", 64'(err), 64'd0);

        // Echoed user mismatch on beat 2.
        req_valid = 3'b001;
        grant_issue(0, 32'h4000_0000, 4'h5, 1'b1, 0);
        for (int b = 0; b < 8; b++) begin
            if (b == 2) check("user_err_before", 64'(err), 64'd0);
            beat(0, b, b == 7, (b == 2) ? 4'h6 : 4'h5);
        end
        check("user_err", 64'(err), 64'd1);
        check("user_idle", 64'(dbg_state), 64'd0);
        repeat (3) tick();
        check("user_err_held", 64'(err), 64'd1);

        // Reset during DATA beat 4 of a requester-1 snoop.
        set_req(1, 32'h2000_0040, 4'h9);
        req_valid = 3'b010;
        grant_issue(1, 32'h2000_0040, 4'h9, 1'b1, 0);
        for (int b = 0; b < 4; b++) beat(1, b, 1'b0, 4'h9);
        cd_valid = 1'b1; cd_data = bd(1, 4); cd_user = 4'h9; resp_ready = 3'b111;
        rst = 1'b1; req_valid = 3'b111;
        #1;
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_cd_ready", 64'(cd_ready), 64'd0);
        check("mid_rst_ac_valid", 64'(ac_valid), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_ac_addr", 64'(ac_addr), 64'd0);
        tick();
        check("mid_rst_state_edge", 64'(dbg_state), 64'd0);
        check("mid_rst_req_ready_edge", 64'(req_ready), 64'd0);
        rst = 1'b0; req_valid = 3'b000; cd_data = bd(1, 5);
        #1;
        check("stray_err_before", 64'(err), 64'd0);
        tick();
        check("stray_err", 64'(err), 64'd1);
        cd_valid = 1'b0; resp_ready = '0;
        set_req(0, 32'h3000_0000, 4'h5);
        req_valid = 3'b111;
        grant_issue(0, 32'h3000_0000, 4'h5, 1'b1, 0);
        for (int b = 0; b < 8; b++) beat(0, b, b == 7, 4'h5);
        check("post_rst_idle", 64'(dbg_state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
